// File: rtl/mmio_tx_fifo_pkg.sv
// Shared constants for the MMIO console output path: byte width, FIFO depth and
// console register offsets so MMIO decode and the TX FIFO agree.
package mmio_tx_fifo_pkg;

  localparam int BYTE_W     = 8;
  localparam int FIFO_DEPTH = 16;

  // Console register offsets within the MMIO console window
  localparam logic [3:0] CONSOLE_DATA_OFS   = 4'h0;
  localparam logic [3:0] CONSOLE_STATUS_OFS = 4'h4;
  localparam logic [3:0] CONSOLE_FLUSH_OFS  = 4'h8;

  // Status read layout: {overflow, count}
  typedef struct packed {
    logic       overflow;
    logic [4:0] count;
  } console_status_t;

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port after the write edge; no backpressure.
module fifo_regfile #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int W      = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mmio_tx_fifo.sv
// Show-ahead byte FIFO from MMIO console stores to the PDU UART transmitter; 1-cycle push-to-out latency.
// Backpressure: in_ready drops when full; a push while full without a pop is dropped and sets sticky overflow.
module mmio_tx_fifo
  import mmio_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  input  logic              out_accept,
  input  logic              flush,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  assign full      = (count == FULL_COUNT);
  assign in_ready  = ~full;
  assign out_valid = (count != '0);
  assign pop       = out_accept & out_valid;
  // A pop frees a slot in the same edge, so a full FIFO still takes a concurrent push
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & ~push;

  fifo_regfile #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (BYTE_W)
  ) u_regfile (
    .clk   (clk),
    .we    (push & ~flush & ~rst),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

endmodule
